// File: rtl/npc_seq_ctrl.sv
// Multi-cycle fetch/decode/execute/writeback sequencer for the NPC core.
// Handles addi and ebreak only; any other word or a missing fetch response faults.
module npc_seq_ctrl #(
    parameter logic [31:0] RESET_PC      = 32'h8000_0000,
    parameter int unsigned FETCH_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rdata,
    output logic [4:0]  rf_raddr,
    input  logic [31:0] rf_rdata,
    output logic [6:0]  ex_op,
    output logic [2:0]  ex_funct3,
    output logic [31:0] ex_src1,
    output logic [11:0] ex_imm,
    input  logic [31:0] ex_result,
    output logic        rf_wen,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [31:0] pc,
    output logic        retire,
    output logic        halt,
    output logic        fault
);

    typedef enum logic [2:0] {
        S_FETCH, S_WAIT, S_DECODE, S_EXEC, S_WB, S_HALT, S_FAULT
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(FETCH_TIMEOUT - 1);

    state_t      state, state_nxt;
    logic [31:0] ir, src1, result;
    logic [7:0]  cnt;
    logic        is_ebreak, is_addi, cnt_last;

    assign is_ebreak = (ir == 32'h0010_0073);
    assign is_addi   = (ir[6:0] == 7'b0010011) && (ir[14:12] == 3'b000);
    assign cnt_last  = (cnt == CNT_LAST);
    assign imem_addr = pc;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_FETCH;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc     <= RESET_PC;
            ir     <= '0;
            src1   <= '0;
            result <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                S_FETCH:  if (imem_req_ready) cnt <= '0;
                S_WAIT: begin
                    if (imem_rsp_valid) ir <= imem_rdata;
                    else                cnt <= cnt + 8'd1;
                end
                S_DECODE: src1   <= rf_rdata;
                S_EXEC:   result <= ex_result;
                S_WB:     pc     <= pc + 32'd4;
                default: ;
            endcase
        end
    end

    // A response in the final allowed WAIT cycle takes priority over the timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH: if (imem_req_ready) state_nxt = S_WAIT;
            S_WAIT: begin
                if (imem_rsp_valid) state_nxt = S_DECODE;
                else if (cnt_last)  state_nxt = S_FAULT;
            end
            S_DECODE: begin
                if (is_ebreak)    state_nxt = S_HALT;
                else if (is_addi) state_nxt = S_EXEC;
                else              state_nxt = S_FAULT;
            end
            S_EXEC:  state_nxt = S_WB;
            S_WB:    state_nxt = S_FETCH;
            S_HALT:  state_nxt = S_HALT;
            S_FAULT: state_nxt = S_FAULT;
            default: state_nxt = S_FAULT;
        endcase
    end

    // Outputs stay quiet while reset is held, whatever the state.
    always_comb begin
        imem_req_valid = 1'b0;
        rf_raddr       = '0;
        ex_op          = '0;
        ex_funct3      = '0;
        ex_src1        = '0;
        ex_imm         = '0;
        rf_wen         = 1'b0;
        rf_waddr       = '0;
        rf_wdata       = '0;
        retire         = 1'b0;
        halt           = 1'b0;
        fault          = 1'b0;
        if (rst_n) begin
            case (state)
                S_FETCH:  imem_req_valid = 1'b1;
                S_DECODE: rf_raddr = ir[19:15];
                S_EXEC: begin
                    ex_op     = ir[6:0];
                    ex_funct3 = ir[14:12];
                    ex_src1   = src1;
                    ex_imm    = ir[31:20];
                end
                S_WB: begin
                    rf_waddr = ir[11:7];
                    rf_wdata = result;
                    rf_wen   = (ir[11:7] != 5'd0);
                    retire   = 1'b1;
                end
                S_HALT:  halt  = 1'b1;
                S_FAULT: fault = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_npc_seq_ctrl.sv
// Testbench for npc_seq_ctrl: directed and randomized instruction streams
// checked against a per-instruction behavioural model.
module tb_npc_seq_ctrl;

    localparam int          TO   = 8;
    localparam logic [31:0] RPC  = 32'h8000_0000;
    localparam logic [31:0] EBRK = 32'h0010_0073;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] rf_rdata = '0;
    logic [31:0] ex_result = '0;
    logic        imem_req_valid;
    logic [31:0] imem_addr;
    logic [4:0]  rf_raddr;
    logic [6:0]  ex_op;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_src1;
    logic [11:0] ex_imm;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] pc;
    logic        retire, halt, fault;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] m_pc;

    npc_seq_ctrl #(.RESET_PC(RPC), .FETCH_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rdata(imem_rdata), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .ex_op(ex_op), .ex_funct3(ex_funct3), .ex_src1(ex_src1),
        .ex_imm(ex_imm), .ex_result(ex_result), .rf_wen(rf_wen),
        .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .pc(pc),
        .retire(retire), .halt(halt), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        repeat (cycles) step();
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_pc", pc, RPC);
        chk("rst_addr", imem_addr, RPC);
        chk("rst_halt", halt, 0);
        chk("rst_fault", fault, 0);
        chk("rst_retire", retire, 0);
        chk("rst_wen", rf_wen, 0);
        chk("rst_ex_op", ex_op, 0);
        rst_n = 1'b1;
        m_pc  = RPC;
        #1;
    endtask

    // After halt/fault: nothing requested, pc frozen, status sticky.
    task automatic hold_dead(input int n, input logic exp_halt);
        for (int i = 0; i < n; i++) begin
            imem_req_ready = 1'($urandom());
            imem_rsp_valid = 1'($urandom());
            imem_rdata     = $urandom();
            chk("dead_req_valid", imem_req_valid, 0);
            chk("dead_pc", pc, m_pc);
            chk("dead_wen", rf_wen, 0);
            chk("dead_retire", retire, 0);
            chk("dead_halt", halt, 32'(exp_halt));
            chk("dead_fault", fault, 32'(!exp_halt));
            step();
        end
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
    endtask

    task automatic do_instr(input logic [31:0] ins, input int rdy_dly,
                            input int rsp_dly, input logic [31:0] rs1v,
                            input logic [31:0] exr);
        for (int i = 0; i < rdy_dly; i++) begin
            chk("stall_req_valid", imem_req_valid, 1);
            chk("stall_addr", imem_addr, m_pc);
            chk("stall_retire", retire, 0);
            step();
        end
        chk("fetch_req_valid", imem_req_valid, 1);
        chk("fetch_addr", imem_addr, m_pc);
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        for (int i = 0; i < rsp_dly && i < TO; i++) begin
            chk("wait_req_valid", imem_req_valid, 0);
            chk("wait_fault", fault, 0);
            chk("wait_raddr", rf_raddr, 0);
            step();
        end
        if (rsp_dly >= TO) begin
            chk("timeout_fault", fault, 1);
            chk("timeout_pc", pc, m_pc);
            hold_dead(4, 1'b0);
            return;
        end
        imem_rsp_valid = 1'b1;
        imem_rdata     = ins;
        step();
        imem_rsp_valid = 1'b0;
        imem_rdata     = $urandom();
        chk("dec_raddr", rf_raddr, 32'(ins[19:15]));
        chk("dec_ex_op", ex_op, 0);
        chk("dec_retire", retire, 0);
        rf_rdata = rs1v;
        step();
        rf_rdata = $urandom();
        if (ins == EBRK) begin
            chk("ebreak_halt", halt, 1);
            hold_dead(20, 1'b1);
            return;
        end
        if (!(ins[6:0] == 7'h13 && ins[14:12] == 3'd0)) begin
            chk("illegal_fault", fault, 1);
            chk("illegal_halt", halt, 0);
            hold_dead(6, 1'b0);
            return;
        end
        chk("ex_op", ex_op, 32'(ins[6:0]));
        chk("ex_funct3", ex_funct3, 32'(ins[14:12]));
        chk("ex_src1", ex_src1, rs1v);
        chk("ex_imm", ex_imm, 32'(ins[31:20]));
        chk("ex_wen", rf_wen, 0);
        ex_result = exr;
        step();
        ex_result = $urandom();
        chk("wb_wen", rf_wen, 32'(ins[11:7] != 5'd0));
        chk("wb_waddr", rf_waddr, 32'(ins[11:7]));
        chk("wb_wdata", rf_wdata, exr);
        chk("wb_retire", retire, 1);
        chk("wb_ex_op", ex_op, 0);
        step();
        m_pc = m_pc + 32'd4;
        chk("next_retire", retire, 0);
        chk("next_pc", pc, m_pc);
        chk("next_req_valid", imem_req_valid, 1);
    endtask

    initial begin
        logic [31:0] w;
        int          r;
        do_reset(2);
        chk("post_rst_req_valid", imem_req_valid, 1);

        do_instr(32'h0050_0093, 0, 0, 32'd0, 32'd5);
        do_instr(32'h0050_0013, 0, 0, 32'd0, 32'd5);
        do_instr(32'h0050_0093, 3, 4, 32'h1234, 32'h1239);
        do_instr(32'hFFF1_0113, 1, TO - 1, 32'd7, 32'd6);
        do_instr(32'h0050_0093, 0, TO, 32'd0, 32'd0);
        do_reset(1);
        do_instr(EBRK, 0, 1, 32'd0, 32'd0);
        do_reset(1);
        do_instr(32'h0000_0033, 0, 0, 32'd0, 32'd0);
        do_reset(1);

        // Reset while a fetch is outstanding, then a stale response.
        do_instr(32'h0010_0093, 0, 0, 32'd0, 32'd1);
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        step();
        rst_n          = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rdata     = EBRK;
        step();
        chk("midrst_req_valid", imem_req_valid, 0);
        rst_n = 1'b1;
        m_pc  = RPC;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("stale_req_valid", imem_req_valid, 1);
            chk("stale_pc", pc, RPC);
            chk("stale_halt", halt, 0);
            chk("stale_fault", fault, 0);
            step();
        end
        imem_rsp_valid = 1'b0;
        do_instr(32'h0030_0193, 0, 0, 32'd9, 32'd12);

        for (int n = 0; n < 60; n++) begin
            r = $urandom_range(0, 11);
            w = {$urandom_range(0, 4095) > 0 ? 12'($urandom()) : 12'd0,
                 5'($urandom()), 3'b000, 5'($urandom()), 7'b0010011};
            if (r == 0) w = EBRK;
            else if (r == 1) w = $urandom();
            do_instr(w, $urandom_range(0, 3),
                     (r == 2) ? TO + $urandom_range(0, 2)
                              : $urandom_range(0, TO - 1),
                     $urandom(), $urandom());
            if (r <= 2 && !(r == 1 && w[6:0] == 7'h13 && w[14:12] == 3'd0))
                do_reset($urandom_range(1, 2));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
